song_sequencer: RTL and testbench
=================================

# song_sequencer

Hardware note sequencer that replaces the simulation-only song driver in front of the Synthesizer. It accepts note events through a valid/ready handshake and converts each tone index into Q12.20 voice frequencies using a just-intonation ratio table. It also drives cutoff and a gate to the synth, and holds each note for a duration counted in audio sample ticks. It sits between the song ROM/CPU event source and the Synthesizer `voice_frequencies`/`cutoff` inputs.

## Interface
- `VOICES`, 8, number of voice frequency outputs.
- `TICKS_PER_UNIT`, 12000, sample ticks per duration unit (1/8 s at 96 kHz).
- `clk` in 1, system clock.
- `reset_n` in 1, reset: one clock; reset is asynchronous and active-low.
- `sample_tick` in 1, one-cycle strobe per audio sample.
- `base_freq` in 32, root frequency, unsigned Q12.20 (110 Hz = 110<<20), sampled at COMPUTE.
- `ev_valid` in 1, event offered.
- `ev_ready` out 1, event accepted when `ev_valid && ev_ready`.
- `ev_tone` in 4, 0–12 = semitone above root; 13–15 = rest.
- `ev_duration` in 8, note length in units.
- `ev_cutoff` in 3, filter cutoff for this note.
- `ev_last` in 1, final event of song.
- `stop` in 1, synchronous abort.
- `frequencies` out VOICES×32, per-voice frequency, signed int Q12.20.
- `cutoff` out 3, current cutoff.
- `gate` out 1, high while a non-rest note plays.
- `done` out 1, one-cycle pulse after the last event completes.

## Operation
- FSM states: IDLE, COMPUTE, PLAY.
- IDLE: `ev_ready = (state==IDLE) && !stop`. On handshake, latch tone/duration/cutoff/last, go to COMPUTE.
- COMPUTE (1 cycle):
  - duration 0: outputs unchanged, no `done`, back to IDLE.
  - Else: load counter = duration×TICKS_PER_UNIT (22-bit). Update `cutoff`.
  - Tone ≤12: `note = (base_freq × RATIO[tone]) >> 20`, a 64-bit product truncated. Voice i = `note << (i%3)`. Each voice saturates to 32'h7FFF_FFFF if the result exceeds 2^31−1. Set `gate=1`.
  - Rest (13–15): frequencies held, `gate=0`.
  - Then go to PLAY.
- PLAY: each `sample_tick` decrements the counter. On a tick with counter==1: `gate←0`, state←IDLE, and `done←1` for one cycle if last.
- Frequencies and cutoff hold their values after a note ends, until the next non-zero-duration event.
- `stop` high in any state: next edge state←IDLE, `gate←0`, counter←0, no `done`; frequencies/cutoff held. `stop` overrides a simultaneous handshake (ready forced 0).
- `sample_tick` during IDLE/COMPUTE is ignored.
- Ratio table (round-to-nearest Q20), tones 0–12: 1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8, 2.

## Timing
- Reset (async, immediate): state IDLE, frequencies all 0, cutoff 0, gate 0, done 0, counter 0. `ev_ready` is 1 whenever state==IDLE and stop=0, including during reset.
- Handshake at edge t0 → COMPUTE during t0..t1. At edge t1, frequencies/cutoff/gate are updated and the state is PLAY. Event-to-output latency is 2 edges.
- Note ends on the edge of the Nth sample_tick after t1, where N = duration×TICKS_PER_UNIT. `done` is high for exactly the following cycle.
- Back-to-back notes: gate low for at least 2 cycles (IDLE plus COMPUTE) between notes. Max throughput is one event per 2 cycles plus play time.
- Reset mid-PLAY: outputs return to reset values immediately, and no `done` pulse is issued.

## Structure
- Package `song_pkg`: `Q_FRAC=20`, `RATIO_Q20[0:12]` constants, `REST_MIN=13`, state enum `seq_state_t`, `SAT_MAX=32'h7FFF_FFFF`.
- Sub-module `tone_freq_calc`: combinational ratio lookup, 32×32 multiply, truncate, per-voice shift and saturation. It is registered by the parent in COMPUTE.
- Parent holds FSM, event latch, counter, and output registers.

## Test plan
- Reset then idle: frequencies 0, gate 0, ev_ready 1; release `reset_n` and no output changes.
- base 110<<20, tone 7, dur 1, cutoff 3, ticks every 4 cycles:
  - At t1: voice0=173015040, voice1=346030080, voice2=692060160, voice3=173015040, cutoff 3, gate 1.
  - gate falls on the 12000th tick.
- base 440<<20, tone 12, last=1, dur 2:
  - voice0=922746880, voice1=1845493760, voice2=7FFF_FFFF (saturated).
  - `done` pulses once after 24000 ticks.
- Sequence tone 3 dur 1, rest (tone 14) dur 1, dur-0 event, tone 0 dur 1:
  - Rest keeps tone-3 frequencies with gate 0.
  - dur-0 event changes nothing and returns ready in 2 cycles.
  - tone 0 gives voice0=base.
- `stop` asserted mid-PLAY, and asserted with ev_valid in IDLE: gate 0 next edge, no done, ev_ready 0 while stop high, no event accepted.
- `reset_n` asserted mid-PLAY: immediate reset values, no done; a new event after release plays normally.

Source files
------------

// File: rtl/song_pkg.sv
// Shared constants and types for the note sequencer.
package song_pkg;

  localparam int          Q_FRAC   = 20;
  localparam logic [3:0]  REST_MIN = 4'd13;
  localparam logic [31:0] SAT_MAX  = 32'h7FFF_FFFF;

  // Just-intonation ratios, Q20, rounded to nearest:
  // 1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8, 2
  localparam logic [31:0] RATIO_Q20 [0:12] = '{
    32'd1048576, 32'd1118481, 32'd1179648, 32'd1258291,
    32'd1310720, 32'd1398101, 32'd1474560, 32'd1572864,
    32'd1677722, 32'd1747627, 32'd1864135, 32'd1966080,
    32'd2097152
  };

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_PLAY    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/song_sequencer_tone_freq_calc.sv
// Combinational tone -> per-voice frequency: ratio lookup, Q12.20 multiply,
// truncate, octave shift per voice and saturation to the signed int range.
module tone_freq_calc
  import song_pkg::*;
#(
  parameter int VOICES = 8
) (
  input  logic [31:0]              i_base_freq,
  input  logic [3:0]               i_tone,
  output logic [VOICES-1:0][31:0]  o_freq
);

  logic [31:0] w_ratio;
  logic [63:0] w_prod;
  logic [45:0] w_note;

  // Rest tones never reach the output registers; feed a zero ratio for them.
  assign w_ratio = (i_tone < REST_MIN) ? RATIO_Q20[i_tone] : 32'd0;
  assign w_prod  = {32'd0, i_base_freq} * {32'd0, w_ratio};
  // Two spare headroom bits above the 44-bit truncated note cover the <<2 voice.
  assign w_note  = 46'(w_prod >> Q_FRAC);

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    logic [45:0] w_shift;
    assign w_shift   = w_note << (v % 3);
    assign o_freq[v] = (w_shift > {14'd0, SAT_MAX}) ? SAT_MAX : w_shift[31:0];
  end

endmodule

// File: rtl/song_sequencer.sv
// Note sequencer: accepts note events, computes voice frequencies, drives
// cutoff/gate and holds each note for duration x TICKS_PER_UNIT sample ticks.
module song_sequencer
  import song_pkg::*;
#(
  parameter int VOICES         = 8,
  parameter int TICKS_PER_UNIT = 12000
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_sample_tick,
  input  logic [31:0]              i_base_freq,
  input  logic                     i_ev_valid,
  output logic                     o_ev_ready,
  input  logic [3:0]               i_ev_tone,
  input  logic [7:0]               i_ev_duration,
  input  logic [2:0]               i_ev_cutoff,
  input  logic                     i_ev_last,
  input  logic                     i_stop,
  output logic [VOICES-1:0][31:0]  o_frequencies,
  output logic [2:0]               o_cutoff,
  output logic                     o_gate,
  output logic                     o_done
);

  localparam logic [21:0] TPU = 22'(TICKS_PER_UNIT);

  seq_state_t              r_state;
  logic [3:0]              r_tone;
  logic [7:0]              r_dur;
  logic [2:0]              r_cut;
  logic                    r_last;
  logic [21:0]             r_cnt;
  logic [VOICES-1:0][31:0] r_freq;
  logic [2:0]              r_cutoff;
  logic                    r_gate;
  logic                    r_done;

  logic [VOICES-1:0][31:0] w_freq;
  logic [21:0]             w_load;

  tone_freq_calc #(.VOICES(VOICES)) u_calc (
    .i_base_freq (i_base_freq),
    .i_tone      (r_tone),
    .o_freq      (w_freq)
  );

  // Max 255 x 12000 fits in 22 bits.
  assign w_load     = 22'(r_dur) * TPU;
  // Stop blocks acceptance so an abort never races a new event.
  assign o_ev_ready = (r_state == S_IDLE) && !i_stop;

  assign o_frequencies = r_freq;
  assign o_cutoff      = r_cutoff;
  assign o_gate        = r_gate;
  assign o_done        = r_done;

  // Sequencer FSM: event latch, note timer and registered synth outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_tone   <= '0;
      r_dur    <= '0;
      r_cut    <= '0;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_freq   <= '0;
      r_cutoff <= '0;
      r_gate   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        // Abort: frequencies and cutoff deliberately held.
        r_state <= S_IDLE;
        r_gate  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_ev_valid) begin
              r_tone  <= i_ev_tone;
              r_dur   <= i_ev_duration;
              r_cut   <= i_ev_cutoff;
              r_last  <= i_ev_last;
              r_state <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            if (r_dur == 8'd0) begin
              // Zero-length event is a no-op, including for a last event.
              r_state <= S_IDLE;
            end else begin
              r_cnt    <= w_load;
              r_cutoff <= r_cut;
              if (r_tone < REST_MIN) begin
                r_freq <= w_freq;
                r_gate <= 1'b1;
              end else begin
                r_gate <= 1'b0;
              end
              r_state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (i_sample_tick) begin
              if (r_cnt == 22'd1) begin
                r_gate  <= 1'b0;
                r_done  <= r_last;
                r_cnt   <= '0;
                r_state <= S_IDLE;
              end else begin
                r_cnt <= r_cnt - 22'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus pushes expected outputs,
// a negedge monitor pops and compares two edges after each handshake.
module tb_song_sequencer;

  localparam int VOICES = 8;
  typedef logic [VOICES-1:0][31:0] fv_t;

  typedef struct {
    fv_t        f;
    logic [2:0] c;
    logic       g;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] base = '0;
  logic        ev_valid = 1'b0;
  logic [3:0]  tone = '0;
  logic [7:0]  dur = '0;
  logic [2:0]  cut = '0;
  logic        ev_last = 1'b0;
  logic        stop = 1'b0;
  logic        ev_ready;
  fv_t         freqs;
  logic [2:0]  cutoff_o;
  logic        gate;
  logic        done;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  bit   done_q[$];

  song_sequencer #(.VOICES(VOICES), .TICKS_PER_UNIT(12000)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_sample_tick (tick),
    .i_base_freq   (base),
    .i_ev_valid    (ev_valid),
    .o_ev_ready    (ev_ready),
    .i_ev_tone     (tone),
    .i_ev_duration (dur),
    .i_ev_cutoff   (cut),
    .i_ev_last     (ev_last),
    .i_stop        (stop),
    .o_frequencies (freqs),
    .o_cutoff      (cutoff_o),
    .o_gate        (gate),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  function automatic fv_t mkf(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    fv_t r;
    for (int i = 0; i < VOICES; i++)
      r[i] = (i % 3 == 0) ? v0 : ((i % 3 == 1) ? v1 : v2);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic check_f(input string name, input fv_t act, input fv_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare outputs the cycle after COMPUTE; account for done pulses.
  bit   hs_d1 = 1'b0;
  bit   hs_d2 = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      hs_d1 = 1'b0;
      hs_d2 = 1'b0;
    end else begin
      if (hs_d2) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: accepted event with no expectation");
        end else begin
          mon_e = exp_q.pop_front();
          check_f("freq", freqs, mon_e.f);
          check("cutoff", 64'(cutoff_o), 64'(mon_e.c));
          check("gate", 64'(gate), 64'(mon_e.g));
        end
      end
      hs_d2 = hs_d1;
      hs_d1 = ev_valid && ev_ready;
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [3:0] t, input logic [7:0] d, input logic [2:0] c, input logic l);
    bit ok = 1'b0;
    @(posedge clk); #1;
    tone = t; dur = d; cut = c; ev_last = l; ev_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ev_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ev_ready got 0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    ev_valid = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (period - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic stop_pulse(input string name);
    stop = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, 64'(ev_ready), 64'd0);
    @(posedge clk); #1;
    stop = 1'b0;
    check({name, "_gate"}, 64'(gate), 64'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check_f({name, "_freq"}, freqs, '0);
    check({name, "_cutoff"}, 64'(cutoff_o), 64'd0);
    check({name, "_gate"}, 64'(gate), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_ready"}, 64'(ev_ready), 64'd1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  fv_t f7, f12, f3, f0, f4;

  initial begin
    f7  = mkf(32'd173015040, 32'd346030080, 32'd692060160);
    f12 = mkf(32'd922746880, 32'd1845493760, 32'h7FFF_FFFF);
    f3  = mkf(32'd138412010, 32'd276824020, 32'd553648040);
    f0  = mkf(32'd115343360, 32'd230686720, 32'd461373440);
    f4  = mkf(32'd144179200, 32'd288358400, 32'd576716800);

    // Reset, then release with nothing offered.
    #2;
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("idle");

    // Tone 7 at 110 Hz, one unit, ticks every 4 cycles.
    base = 32'd110 << 20;
    exp_q.push_back('{f7, 3'd3, 1'b1});
    send(4'd7, 8'd1, 3'd3, 1'b0);
    @(posedge clk); #1;
    run_ticks(11999, 4);
    @(negedge clk);
    check("t7_gate_before_end", 64'(gate), 64'd1);
    run_ticks(1, 4);
    @(negedge clk);
    check("t7_gate_after_end", 64'(gate), 64'd0);
    check("t7_ready_after_end", 64'(ev_ready), 64'd1);

    // Tone 12 at 440 Hz, two units, last: saturation and done pulse.
    base = 32'd440 << 20;
    exp_q.push_back('{f12, 3'd5, 1'b1});
    done_q.push_back(1'b1);
    send(4'd12, 8'd2, 3'd5, 1'b1);
    @(posedge clk); #1;
    run_ticks(23999, 1);
    check("t12_gate_before_end", 64'(gate), 64'd1);
    check("t12_done_before_end", 64'(done), 64'd0);
    run_ticks(1, 1);
    check("t12_gate_end", 64'(gate), 64'd0);
    check("t12_done_end", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("t12_done_one_cycle", 64'(done), 64'd0);

    // Sequence: tone 3, rest, zero-duration, tone 0 (notes cut short by stop).
    base = 32'd110 << 20;
    exp_q.push_back('{f3, 3'd2, 1'b1});
    send(4'd3, 8'd1, 3'd2, 1'b0);
    @(posedge clk); #1;
    stop_pulse("stop_t3");

    exp_q.push_back('{f3, 3'd6, 1'b0});
    send(4'd14, 8'd1, 3'd6, 1'b0);
    @(posedge clk); #1;
    stop_pulse("stop_rest");

    exp_q.push_back('{f3, 3'd6, 1'b0});
    send(4'd4, 8'd0, 3'd7, 1'b1);
    @(negedge clk);
    check("dur0_ready_compute", 64'(ev_ready), 64'd0);
    @(negedge clk);
    check("dur0_ready_back", 64'(ev_ready), 64'd1);

    // Tone 0, last, stopped mid-play: no done, outputs held.
    exp_q.push_back('{f0, 3'd1, 1'b1});
    send(4'd0, 8'd1, 3'd1, 1'b1);
    @(posedge clk); #1;
    run_ticks(50, 1);
    check("t0_gate_playing", 64'(gate), 64'd1);
    stop_pulse("stop_t0");
    check_f("stop_t0_freq_held", freqs, f0);
    check("stop_t0_cutoff_held", 64'(cutoff_o), 64'd1);

    // Stop together with an offered event in IDLE: nothing accepted.
    @(posedge clk); #1;
    stop = 1'b1; ev_valid = 1'b1; tone = 4'd5; dur = 8'd1; cut = 3'd4; ev_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stop_idle_ready", 64'(ev_ready), 64'd0);
    end
    @(posedge clk); #1;
    ev_valid = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("stop_idle_ready_back", 64'(ev_ready), 64'd1);
    check("stop_idle_gate", 64'(gate), 64'd0);
    check_f("stop_idle_freq", freqs, f0);

    // Reset mid-play, then a fresh note.
    exp_q.push_back('{f7, 3'd3, 1'b1});
    send(4'd7, 8'd1, 3'd3, 1'b1);
    @(posedge clk); #1;
    run_ticks(20, 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("postreset");

    exp_q.push_back('{f4, 3'd4, 1'b1});
    send(4'd4, 8'd1, 3'd4, 1'b0);
    @(posedge clk); #1;
    run_ticks(100, 1);
    check("t4_gate_playing", 64'(gate), 64'd1);
    stop_pulse("stop_t4");

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("done_drained", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
